wish_unpack: RTL and testbench
==============================

// Module: wish_unpack
// PURPOSE
//  Width converter, inverse of wish_pack: accepts one wide word (NUM_PACK x DATA_WIDTH) on a
//  Wishbone-style slave port, emits NUM_PACK narrow beats on a Wishbone-style master port.
//  Sits between wide-bus producers and narrow sinks such as wish_writeIntegers.
//  Tag bits are carried through: tgc[0]=first, tgc[1]=last.
// PARAMETERS
//  DATA_WIDTH    8  width of one narrow output beat
//  NUM_PACK      4  narrow beats per wide input word (>=1)
//  TGC_WIDTH     2  tag width (>=2); bit0=first, bit1=last, upper bits user tags
//  LITTLE_ENDIAN 0  0: beat 0 = most-significant slice; 1: beat 0 = bits [DATA_WIDTH-1:0]
// PORTS
//  clk_i      in   1                     clock, all logic on rising edge
//  rst_i      in   1                     reset, asynchronous, active-low
//  s_stb_i    in   1                     slave strobe
//  s_cyc_i    in   1                     slave cycle
//  s_ack_o    out  1                     slave ack, word accepted this cycle
//  s_stall_o  out  1                     slave stall, cannot accept this cycle
//  s_dat_i    in   DATA_WIDTH*NUM_PACK   wide input word
//  s_tgc_i    in   TGC_WIDTH             input tags
//  d_stb_o    out  1                     master strobe, beat valid
//  d_cyc_o    out  1                     master cycle (== d_stb_o)
//  d_ack_i    in   1                     master ack, beat consumed this cycle
//  d_dat_o    out  DATA_WIDTH            narrow output beat
//  d_tgc_o    out  TGC_WIDTH             output tags
// BEHAVIOUR
//  - Reset (rst_i=0, async): state=IDLE, idx=0, d_stb_o=d_cyc_o=0, d_dat_o=0, d_tgc_o=0,
//    holding regs cleared; s_stall_o=1 while in reset. Word in flight is discarded.
//  - FSM: IDLE (no word held), SHIFT (word held, idx = current beat 0..NUM_PACK-1).
//  - ready = (IDLE) | (SHIFT & idx==NUM_PACK-1 & d_ack_i). s_stall_o = ~ready.
//    s_ack_o = s_stb_i & s_cyc_i & ready (combinational, same cycle as accept).
//  - Accept: on edge with s_ack_o=1, latch s_dat_i/s_tgc_i, idx<=0, state<=SHIFT.
//    Latency 1 cycle: d_stb_o high the cycle after accept.
//  - Beat done = d_stb_o & d_ack_i. Not last: idx<=idx+1. Last: next word accepted same edge
//    if s_ack_o, else state<=IDLE, d_stb_o<=0. Zero-bubble: back-to-back words stream at
//    1 beat/cycle under continuous d_ack_i.
//  - d_ack_i while d_stb_o=0 ignored. s_stb_i/s_cyc_i changes during SHIFT ignored.
//  - d_dat_o: slice idx (LITTLE_ENDIAN=1) or slice NUM_PACK-1-idx (LITTLE_ENDIAN=0),
//    slice k = s_dat[k*DATA_WIDTH +: DATA_WIDTH]. Stable while d_stb_o & ~d_ack_i.
//  - d_tgc_o[0] = tgc[0] & idx==0; d_tgc_o[1] = tgc[1] & idx==NUM_PACK-1;
//    d_tgc_o[TGC_WIDTH-1:2] = latched tags on every beat.
//  - idx width max(1,$clog2(NUM_PACK)); never exceeds NUM_PACK-1, no wrap past last.
//  - NUM_PACK=1: pure one-entry register slice, every beat carries first and last as input.
// TESTING
//  1 Reset asserted mid-sim -> d_stb_o=d_cyc_o=0, d_dat_o=0, d_tgc_o=0, s_stall_o=1 immediately.
//  2 LE=0, word 0x11223344 tgc=2'b11, d_ack_i=1 -> beats 11,22,33,44 on 4 consecutive cycles;
//    tgc 01,00,00,10; s_ack_o single pulse.
//  3 LE=1, same word -> beats 44,33,22,11; first on 44, last on 11.
//  4 Words 0xA0A1A2A3, 0xB0B1B2B3 back-to-back, continuous ack -> 8 beats in 8 cycles, no gap;
//    2nd s_ack_o coincides with beat A3 acked.
//  5 d_ack_i low 3 cycles at beat 2 of 0x11223344 (LE=0) -> d_dat_o holds 0x33, d_stb_o=1,
//    s_stall_o=1 throughout; resumes with 0x44.
//  6 rst_i pulsed low after 2 beats -> outputs idle; next word 0x55667788 starts at beat 0x55
//    with first=1.

Source files
------------

// File: rtl/wish_unpack.sv
// Splits one wide word into NUM_PACK narrow beats; first beat is registered one cycle after accept.
// Next word is accepted only on the edge that consumes the last beat; d_ack_i low freezes the beat.
module wish_unpack #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_PACK      = 4,
  parameter int TGC_WIDTH     = 2,
  parameter int LITTLE_ENDIAN = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_stb_i,
  input  logic                           s_cyc_i,
  output logic                           s_ack_o,
  output logic                           s_stall_o,
  input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  output logic                           d_stb_o,
  output logic                           d_cyc_o,
  input  logic                           d_ack_i,
  output logic [DATA_WIDTH-1:0]          d_dat_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o
);

  localparam int WW    = DATA_WIDTH * NUM_PACK;
  localparam int IDX_W = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PACK - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WW-1:0]          dat_q;
  logic [TGC_WIDTH-1:0]   tgc_q;
  logic                   d_stb_q;
  logic [DATA_WIDTH-1:0]  d_dat_q;
  logic [TGC_WIDTH-1:0]   d_tgc_q;
  logic                   last_beat;
  logic                   ready;

  function automatic logic [DATA_WIDTH-1:0] beat_of(input logic [WW-1:0] w,
                                                    input logic [IDX_W-1:0] i);
    int k;
    k = (LITTLE_ENDIAN != 0) ? int'(i) : NUM_PACK - 1 - int'(i);
    return DATA_WIDTH'(w >> (k * DATA_WIDTH));
  endfunction

  // first/last qualified by beat position; user tag bits ride along on every beat
  function automatic logic [TGC_WIDTH-1:0] tag_of(input logic [TGC_WIDTH-1:0] t,
                                                  input logic [IDX_W-1:0] i);
    logic [TGC_WIDTH-1:0] r;
    r    = t;
    r[0] = t[0] & (i == '0);
    r[1] = t[1] & (i == IDX_LAST);
    return r;
  endfunction

  assign idx_d     = idx_q + IDX_W'(1);
  assign last_beat = (idx_q == IDX_LAST);
  assign ready     = rst_i & ((state_q == IDLE) | ((state_q == SHIFT) & last_beat & d_ack_i));
  assign s_stall_o = ~ready;
  assign s_ack_o   = s_stb_i & s_cyc_i & ready;
  assign d_stb_o   = d_stb_q;
  assign d_cyc_o   = d_stb_q;
  assign d_dat_o   = d_dat_q;
  assign d_tgc_o   = d_tgc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dat_q   <= '0;
      tgc_q   <= '0;
      d_stb_q <= 1'b0;
      d_dat_q <= '0;
      d_tgc_q <= '0;
    end else if (s_ack_o) begin
      state_q <= SHIFT;
      idx_q   <= '0;
      dat_q   <= s_dat_i;
      tgc_q   <= s_tgc_i;
      d_stb_q <= 1'b1;
      d_dat_q <= beat_of(s_dat_i, '0);
      d_tgc_q <= tag_of(s_tgc_i, '0);
    end else if ((state_q == SHIFT) && d_ack_i) begin
      if (last_beat) begin
        state_q <= IDLE;
        d_stb_q <= 1'b0;
      end else begin
        idx_q   <= idx_d;
        d_dat_q <= beat_of(dat_q, idx_d);
        d_tgc_q <= tag_of(tgc_q, idx_d);
      end
    end
  end

endmodule

// File: tb/tb_wish_unpack.sv
// Bench for wish_unpack: big- and little-endian instances share stimulus, beats scored from a queue.
module tb_wish_unpack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_stb, s_cyc, d_ack;
  logic [31:0] s_dat;
  logic [1:0]  s_tgc;

  logic       ack_be, stall_be, stb_be, cyc_be;
  logic [7:0] dat_be;
  logic [1:0] tgc_be;
  logic       ack_le, stall_le, stb_le, cyc_le;
  logic [7:0] dat_le;
  logic [1:0] tgc_le;

  typedef struct packed {
    logic [7:0] be;
    logic [7:0] le;
    logic [1:0] tg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   beats  = 0;
  int   b0;

  always #5 clk = ~clk;

  wish_unpack #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(0)) u_be (
    .clk_i(clk), .rst_i(rst_n), .s_stb_i(s_stb), .s_cyc_i(s_cyc),
    .s_ack_o(ack_be), .s_stall_o(stall_be), .s_dat_i(s_dat), .s_tgc_i(s_tgc),
    .d_stb_o(stb_be), .d_cyc_o(cyc_be), .d_ack_i(d_ack), .d_dat_o(dat_be), .d_tgc_o(tgc_be)
  );

  wish_unpack #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1)) u_le (
    .clk_i(clk), .rst_i(rst_n), .s_stb_i(s_stb), .s_cyc_i(s_cyc),
    .s_ack_o(ack_le), .s_stall_o(stall_le), .s_dat_i(s_dat), .s_tgc_i(s_tgc),
    .d_stb_o(stb_le), .d_cyc_o(cyc_le), .d_ack_i(d_ack), .d_dat_o(dat_le), .d_tgc_o(tgc_le)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_word(input logic [31:0] w, input logic [1:0] t);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.be = w[(3-i)*8 +: 8];
      e.le = w[i*8 +: 8];
      e.tg = {t[1] & (i == 3), t[0] & (i == 0)};
      q.push_back(e);
    end
  endtask

  // Sample at the falling edge, score any handshaked beat, then advance past the rising edge.
  task automatic step(input logic exp_ack);
    exp_t e;
    @(negedge clk);
    chk("s_ack_be", ack_be, exp_ack);
    chk("s_ack_le", ack_le, exp_ack);
    if (stb_be && d_ack) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = q.pop_front();
        beats++;
        chk("be_dat", dat_be, e.be);
        chk("le_dat", dat_le, e.le);
        chk("be_tgc", tgc_be, e.tg);
        chk("le_tgc", tgc_le, e.tg);
        chk("cyc_be", cyc_be, 1);
        chk("stb_le", stb_le, 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stb"}, stb_be, 0);
    chk({tag, "_cyc"}, cyc_le, 0);
    chk({tag, "_dat"}, dat_be, 0);
    chk({tag, "_tgc"}, tgc_le, 0);
    chk({tag, "_stall"}, stall_be, 1);
  endtask

  initial begin
    rst_n = 1'b0; s_stb = 1'b0; s_cyc = 1'b0; d_ack = 1'b0; s_dat = '0; s_tgc = '0;
    #1;
    chk_idle("rst0");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("idle_stall", stall_be, 0);

    // big/little-endian single word under continuous ack
    d_ack = 1'b1; s_stb = 1'b1; s_cyc = 1'b1; s_dat = 32'h1122_3344; s_tgc = 2'b11;
    push_word(s_dat, s_tgc);
    step(1'b1);
    s_stb = 1'b0;
    b0 = beats;
    repeat (4) step(1'b0);
    chk("t2_beats", beats - b0, 4);
    chk("t2_done_stb", stb_be, 0);

    // back-to-back words, no bubble; second ack lands with the last beat of the first word
    s_stb = 1'b1; s_dat = 32'hA0A1_A2A3; s_tgc = 2'b11;
    push_word(s_dat, s_tgc);
    step(1'b1);
    s_dat = 32'hB0B1_B2B3;
    push_word(s_dat, s_tgc);
    b0 = beats;
    step(1'b0); step(1'b0); step(1'b0);
    step(1'b1);
    s_stb = 1'b0;
    repeat (4) step(1'b0);
    chk("t4_beats", beats - b0, 8);
    chk("t4_q_empty", q.size(), 0);

    // backpressure on beat 2
    s_stb = 1'b1; s_dat = 32'h1122_3344; s_tgc = 2'b11;
    push_word(s_dat, s_tgc);
    step(1'b1);
    s_stb = 1'b0;
    step(1'b0); step(1'b0);
    d_ack = 1'b0;
    s_stb = 1'b1; s_dat = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_be", dat_be, 8'h33);
      chk("t5_hold_le", dat_le, 8'h22);
      chk("t5_stb", stb_be, 1);
      chk("t5_stall", stall_be, 1);
      step(1'b0);
    end
    s_stb = 1'b0;
    d_ack = 1'b1;
    step(1'b0);
    chk("t5_resume", dat_be, 8'h44);
    step(1'b0);
    chk("t5_q_empty", q.size(), 0);

    // reset mid-word discards the remainder
    s_stb = 1'b1; s_dat = 32'h1122_3344; s_tgc = 2'b11;
    push_word(s_dat, s_tgc);
    step(1'b1);
    s_stb = 1'b0;
    step(1'b0); step(1'b0);
    rst_n = 1'b0;
    #1;
    chk_idle("rst1");
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_stb = 1'b1; s_dat = 32'h5566_7788; s_tgc = 2'b11;
    push_word(s_dat, s_tgc);
    step(1'b1);
    s_stb = 1'b0;
    chk("t6_first_dat", dat_be, 8'h55);
    chk("t6_first_tgc", tgc_be, 2'b01);
    b0 = beats;
    repeat (4) step(1'b0);
    chk("t6_beats", beats - b0, 4);
    chk("t6_q_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
